debug_access_gate: RTL and testbench

//  Authenticated gate downstream of the secure processor core. Consumes the core's result and

---
 rtl/dbg_gate_pkg.sv | 17 +
 rtl/dbg_gate_timer.sv | 30 +++
 rtl/debug_access_gate.sv | 177 +++++++++++++++++
 tb/tb_debug_access_gate.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_gate_pkg.sv
// Shared op encodings and FSM state type for the debug access gate.
// Imported by debug_access_gate and dbg_gate_timer.
package dbg_gate_pkg;

    localparam logic [1:0] OP_READ_RESULT = 2'b00;
    localparam logic [1:0] OP_READ_DEBUG  = 2'b01;
    localparam logic [1:0] OP_UNLOCK      = 2'b10;
    localparam logic [1:0] OP_LOCK        = 2'b11;

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_CHECK,
        ST_UNLOCKED,
        ST_LOCKOUT
    } state_e;

endpackage

// File: rtl/dbg_gate_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Load wins over enable; the count holds at zero once reached.
module dbg_gate_timer
    import dbg_gate_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/debug_access_gate.sv
// Token-authenticated gate in front of the core debug register, with lockout.
// Define DBG_SESSION_TIMEOUT_EN to auto-relock an idle UNLOCKED session.
module debug_access_gate
    import dbg_gate_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic [1:0]        dbg_req_op,
    input  logic [DATA_W-1:0] dbg_req_data,
    output logic              dbg_rsp_valid,
    output logic [DATA_W-1:0] dbg_rsp_data,
    output logic              dbg_rsp_err,
    input  logic [DATA_W-1:0] fuse_key,
    input  logic              fuse_valid,
    input  logic [DATA_W-1:0] core_result,
    input  logic [DATA_W-1:0] core_debug,
    output logic              dbg_unlocked,
    output logic              dbg_lockout
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES);

    state_e            state_q, state_d;
    logic [FW-1:0]     fail_q, fail_d, fail_inc;
    logic [DATA_W-1:0] token_q;
    logic              tok_load;
    logic              lock_load;
    logic              lock_done;
    logic              accept;
    logic              match;
    logic              rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0] rsp_data_d;

    assign dbg_req_ready = (state_q != ST_CHECK);
    assign accept        = dbg_req_valid & dbg_req_ready;
    assign match         = fuse_valid & (token_q == fuse_key);
    assign dbg_unlocked  = (state_q == ST_UNLOCKED);
    assign dbg_lockout   = (state_q == ST_LOCKOUT);

    assign fail_inc = (fail_q == FW'(MAX_FAILS)) ? fail_q
                                                 : fail_q + 1'b1;

    dbg_gate_timer #(.W(LW)) u_lock_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (lock_load),
        .load_val (LW'(LOCKOUT_CYCLES - 1)),
        .en       (state_q == ST_LOCKOUT),
        .done     (lock_done)
    );

`ifdef DBG_SESSION_TIMEOUT_EN
    localparam int TC = (TIMEOUT_CYCLES < 2) ? 2 : TIMEOUT_CYCLES;
    localparam int TW = $clog2(TC);

    logic sess_load;
    logic sess_done;

    // Reload on entry to UNLOCKED and on every accepted request there.
    assign sess_load = (state_q == ST_CHECK && match) ||
                       (state_q == ST_UNLOCKED && accept);

    dbg_gate_timer #(.W(TW)) u_sess_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (sess_load),
        .load_val (TW'(TIMEOUT_CYCLES - 1)),
        .en       (state_q == ST_UNLOCKED && !accept),
        .done     (sess_done)
    );
`endif

    always_comb begin
        state_d     = state_q;
        fail_d      = fail_q;
        tok_load    = 1'b0;
        lock_load   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        unique case (state_q)
            ST_LOCKED: begin
                if (accept) begin
                    unique case (1'b1)
                        dbg_req_op == OP_READ_RESULT: begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = core_result;
                        end
                        dbg_req_op == OP_READ_DEBUG: begin
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end
                        dbg_req_op == OP_UNLOCK: begin
                            tok_load = 1'b1;
                            state_d  = ST_CHECK;
                        end
                        default: rsp_valid_d = 1'b1;
                    endcase
                end
            end
            ST_CHECK: begin
                rsp_valid_d = 1'b1;
                if (match) begin
                    fail_d  = '0;
                    state_d = ST_UNLOCKED;
                end else begin
                    fail_d    = fail_inc;
                    rsp_err_d = 1'b1;
                    if (fail_inc == FW'(MAX_FAILS)) begin
                        lock_load = 1'b1;
                        state_d   = ST_LOCKOUT;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    unique case (1'b1)
                        dbg_req_op == OP_READ_RESULT:
                            rsp_data_d = core_result;
                        dbg_req_op == OP_READ_DEBUG:
                            rsp_data_d = core_debug;
                        dbg_req_op == OP_LOCK:
                            state_d = ST_LOCKED;
                        default: ;
                    endcase
                end
`ifdef DBG_SESSION_TIMEOUT_EN
                else if (sess_done) begin
                    state_d = ST_LOCKED;
                end
`endif
            end
            default: begin
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
                if (lock_done) begin
                    fail_d  = '0;
                    state_d = ST_LOCKED;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOCKED;
            fail_q        <= '0;
            token_q       <= '0;
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_data  <= '0;
            dbg_rsp_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fail_q        <= fail_d;
            dbg_rsp_valid <= rsp_valid_d;
            dbg_rsp_data  <= rsp_data_d;
            dbg_rsp_err   <= rsp_err_d;
            if (tok_load) begin
                token_q <= dbg_req_data;
            end
        end
    end

endmodule

// File: tb/tb_debug_access_gate.sv
// Scoreboard bench for debug_access_gate (define DBG_SESSION_TIMEOUT_EN
// to also exercise the idle relock with TIMEOUT_CYCLES=16).
module tb_debug_access_gate;
    import dbg_gate_pkg::*;

    localparam logic [31:0] KEY = 32'hCAFEF00D;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = OP_LOCK;
    logic [31:0] req_data = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] fuse_key = '0;
    logic        fuse_valid = 1'b0;
    logic [31:0] core_result = '0;
    logic [31:0] core_debug = '0;
    logic        unlocked;
    logic        lockout;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    debug_access_gate #(
        .DATA_W         (32),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (1024),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dbg_req_valid (req_valid),
        .dbg_req_ready (req_ready),
        .dbg_req_op    (req_op),
        .dbg_req_data  (req_data),
        .dbg_rsp_valid (rsp_valid),
        .dbg_rsp_data  (rsp_data),
        .dbg_rsp_err   (rsp_err),
        .fuse_key      (fuse_key),
        .fuse_valid    (fuse_valid),
        .core_result   (core_result),
        .core_debug    (core_debug),
        .dbg_unlocked  (unlocked),
        .dbg_lockout   (lockout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    if (e.due != 0) check("rsp_lat", cyc, e.due);
                end
            end else begin
                check("idle_data", rsp_data, 32'd0);
            end
        end
    end

    // lat=0 means the response cycle is not checked
    task automatic send(input logic [1:0] op, input logic [31:0] d,
                        input logic [31:0] ed, input logic ee,
                        input int lat);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("req_ready", {31'd0, req_ready}, 32'd1);
        e.due  = (lat == 0) ? 0 : cyc + lat;
        e.data = ed;
        e.err  = ee;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        check("drain", sb.size(), 32'd0);
    endtask

    task automatic wait_lockout(input logic lvl, input int lim,
                                output int at);
        int n;
        n = 0;
        while (lockout !== lvl && n < lim) begin
            n++;
            @(negedge clk);
        end
        at = cyc;
    endtask

    task automatic wait_unlocked(input logic lvl, input int lim,
                                 output int at);
        int n;
        n = 0;
        while (unlocked !== lvl && n < lim) begin
            n++;
            @(negedge clk);
        end
        at = cyc;
    endtask

    initial begin
        int t0;
        int t1;
        int nrsp;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_unlocked", {31'd0, unlocked}, 32'd0);
        check("rst_lockout", {31'd0, lockout}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        mon_en = 1'b1;

        core_result = 32'h1234;
        core_debug  = 32'hDEADBEEF;
        send(OP_READ_DEBUG, 32'h0, 32'h0, 1'b1, 1);
        send(OP_READ_RESULT, 32'h0, 32'h1234, 1'b0, 1);
        send(OP_LOCK, 32'h0, 32'h0, 1'b0, 1);
        drain();

        fuse_key   = KEY;
        fuse_valid = 1'b1;
        send(OP_UNLOCK, KEY, 32'h0, 1'b0, 2);
        drain();
        check("unlock_ok", {31'd0, unlocked}, 32'd1);
        send(OP_READ_DEBUG, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        core_result = 32'h00C0FFEE;
        send(OP_READ_RESULT, 32'h0, 32'h00C0FFEE, 1'b0, 1);
        send(OP_LOCK, 32'h0, 32'h0, 1'b0, 1);
        drain();
        check("lock_relock", {31'd0, unlocked}, 32'd0);
        send(OP_READ_DEBUG, 32'h0, 32'h0, 1'b1, 1);
        drain();

        send(OP_UNLOCK, 32'h0, 32'h0, 1'b1, 2);
        send(OP_UNLOCK, 32'h0, 32'h0, 1'b1, 2);
        drain();
        check("no_lockout_2fails", {31'd0, lockout}, 32'd0);
        send(OP_UNLOCK, 32'h0, 32'h0, 1'b1, 2);
        wait_lockout(1'b1, 10, t0);
        check("lockout_rise", {31'd0, lockout}, 32'd1);
        send(OP_UNLOCK, KEY, 32'h0, 1'b1, 0);
        send(OP_READ_DEBUG, 32'h0, 32'h0, 1'b1, 1);
        send(OP_READ_RESULT, 32'h0, 32'h0, 1'b1, 1);
        drain();
        check("lockout_no_unlock", {31'd0, unlocked}, 32'd0);
        wait_lockout(1'b0, 1100, t1);
        check("lockout_fall", {31'd0, lockout}, 32'd0);
        check("lockout_len", t1 - t0, 32'd1024);
        send(OP_UNLOCK, KEY, 32'h0, 1'b0, 2);
        drain();
        check("unlock_after_lockout", {31'd0, unlocked}, 32'd1);
        send(OP_LOCK, 32'h0, 32'h0, 1'b0, 1);
        drain();

        fuse_valid = 1'b0;
        send(OP_UNLOCK, KEY, 32'h0, 1'b1, 2);
        drain();
        check("fuse_invalid", {31'd0, unlocked}, 32'd0);
        fuse_valid = 1'b1;
        send(OP_UNLOCK, 32'h5, 32'h0, 1'b1, 2);
        drain();
        check("fail_cnt_2", {31'd0, lockout}, 32'd0);
        send(OP_UNLOCK, 32'h5, 32'h0, 1'b1, 2);
        wait_lockout(1'b1, 10, t0);
        check("fail_cnt_3", {31'd0, lockout}, 32'd1);
        drain();
        wait_lockout(1'b0, 1100, t1);
        check("lockout2_fall", {31'd0, lockout}, 32'd0);

        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = OP_UNLOCK;
        req_data  = KEY;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nrsp = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) nrsp++;
        end
        check("rst_check_norsp", nrsp, 32'd0);
        check("rst_check_locked", {31'd0, unlocked}, 32'd0);
        check("rst_check_ready", {31'd0, req_ready}, 32'd1);
        send(OP_READ_DEBUG, 32'h0, 32'h0, 1'b1, 1);
        drain();

`ifdef DBG_SESSION_TIMEOUT_EN
        send(OP_UNLOCK, KEY, 32'h0, 1'b0, 2);
        wait_unlocked(1'b1, 10, t0);
        check("sess_unlock", {31'd0, unlocked}, 32'd1);
        wait_unlocked(1'b0, 40, t1);
        check("sess_timeout", {31'd0, unlocked}, 32'd0);
        check("sess_len", t1 - t0, 32'd16);
        drain();
        send(OP_UNLOCK, KEY, 32'h0, 1'b0, 2);
        wait_unlocked(1'b1, 10, t0);
        while (cyc < t0 + 14) @(negedge clk);
        send(OP_READ_DEBUG, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        drain();
        check("sess_edge_keep", {31'd0, unlocked}, 32'd1);
        send(OP_LOCK, 32'h0, 32'h0, 1'b0, 1);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
